// File: rtl/gestor_llamadas_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gestor_llamadas_pkg: floor one-hot codes, scheduler states, bit helpers      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package gestor_llamadas_pkg;

  // Same encoding as the hoist FSM: bit4 = floor1 ... bit0 = floor5
  localparam logic [4:0] P1 = 5'b10000;
  localparam logic [4:0] P2 = 5'b01000;
  localparam logic [4:0] P3 = 5'b00100;
  localparam logic [4:0] P4 = 5'b00010;
  localparam logic [4:0] P5 = 5'b00001;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    DESTINO  = 2'd1,
    LLEGADA  = 2'd2
  } estado_t;

  function automatic logic [4:0] bit_alto(input logic [4:0] x);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (x[i]) r = 5'b00001 << i;
    end
    return r;
  endfunction

  function automatic logic [4:0] bit_bajo(input logic [4:0] x);
    return x & (~x + 5'd1);
  endfunction

  function automatic logic es_unico(input logic [4:0] x);
    return (x != 5'd0) && ((x & (x - 5'd1)) == 5'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gestor_llamadas_antirrebote.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gestor_llamadas_antirrebote: one-button debouncer with rising-edge pulse     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module gestor_llamadas_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_boton,
  output logic o_pulso
);

  localparam logic [CNT_W-1:0] c_LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_acc_d;

  // Accepted level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_acc_d <= 1'b0;
    end else begin
      r_acc_d <= r_acc;
      if (i_boton == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LIMITE) begin
        r_acc <= i_boton;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulso = r_acc & ~r_acc_d;

endmodule
`default_nettype wire

// File: rtl/gestor_llamadas.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gestor_llamadas: call debounce/latch and elevator scheduling for the hoist   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module gestor_llamadas
  import gestor_llamadas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] boton,
  input  logic       fc1,
  input  logic       fc2,
  input  logic       fc3,
  input  logic       fc4,
  input  logic       fc5,
  input  logic       emergencia,
  output logic [4:0] selector,
  output logic [4:0] pendientes,
  output logic       dir_subida
);

  logic [4:0] w_fc;
  logic [4:0] w_pulso;
  logic [4:0] w_sube;
  logic [4:0] w_baja;
  logic [4:0] w_sel_sig;
  logic [4:0] w_clr;
  logic       w_dir_sig;
  estado_t    w_estado_sig;

  estado_t    r_estado;
  logic [4:0] r_sel;
  logic [4:0] r_pend;
  logic [4:0] r_piso;
  logic       r_dir;

  assign w_fc = (fc1 ? P1 : 5'd0) | (fc2 ? P2 : 5'd0) | (fc3 ? P3 : 5'd0)
              | (fc4 ? P4 : 5'd0) | (fc5 ? P5 : 5'd0);

  for (genvar g = 0; g < 5; g++) begin : g_antirrebote
    gestor_llamadas_antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_antirrebote (
      .clk    (clk),
      .reset  (reset),
      .i_boton(boton[g]),
      .o_pulso(w_pulso[g])
    );
  end

  // Upward floors sit at lower bit indices than the current one-hot position
  assign w_sube = r_pend & (r_piso - 5'd1);
  assign w_baja = r_pend & ~(r_piso | (r_piso - 5'd1));

  always_comb begin
    w_estado_sig = r_estado;
    w_sel_sig    = r_sel;
    w_dir_sig    = r_dir;
    w_clr        = '0;
    if (emergencia) begin
      w_estado_sig = INACTIVO;
      w_sel_sig    = '0;
      w_dir_sig    = 1'b0;
    end else begin
      case (r_estado)
        INACTIVO: begin
          w_sel_sig = '0;
          if (r_pend != 5'd0) begin
            w_estado_sig = DESTINO;
            if (r_dir && (w_sube != 5'd0)) begin
              w_sel_sig = bit_alto(w_sube);
            end else if (!r_dir && (w_baja != 5'd0)) begin
              w_sel_sig = bit_bajo(w_baja);
            end else if (r_dir && (w_baja != 5'd0)) begin
              w_sel_sig = bit_bajo(w_baja);
              w_dir_sig = 1'b0;
            end else if (!r_dir && (w_sube != 5'd0)) begin
              w_sel_sig = bit_alto(w_sube);
              w_dir_sig = 1'b1;
            end else begin
              // Only the last known floor is pending: send the car there
              w_sel_sig = r_piso;
            end
          end
        end
        DESTINO: begin
          if ((w_fc & r_sel) != 5'd0) begin
            w_clr        = r_sel;
            w_sel_sig    = '0;
            w_estado_sig = LLEGADA;
          end
        end
        LLEGADA: begin
          w_sel_sig    = '0;
          w_estado_sig = INACTIVO;
        end
        default: begin
          w_sel_sig    = '0;
          w_estado_sig = INACTIVO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_estado <= INACTIVO;
    else        r_estado <= w_estado_sig;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel  <= '0;
      r_pend <= '0;
      r_piso <= P1;
      r_dir  <= 1'b1;
    end else begin
      r_sel <= w_sel_sig;
      r_dir <= w_dir_sig;
      // Clear after set so an arrival wins over a same-cycle call for that floor
      r_pend <= emergencia ? 5'd0 : ((r_pend | (w_pulso & ~w_fc)) & ~w_clr);
      if (es_unico(w_fc)) r_piso <= w_fc;
    end
  end

  assign selector   = r_sel;
  assign pendientes = r_pend;
  assign dir_subida = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_gestor_llamadas.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_gestor_llamadas: directed plan plus random soak against a floor model     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_gestor_llamadas;

  localparam int DEB = 16;

  logic       clk;
  logic       reset;
  logic [4:0] boton;
  logic [4:0] fcv;
  logic       emergencia;
  logic [4:0] selector;
  logic [4:0] pendientes;
  logic       dir_subida;

  int n_chk;
  int n_err;

  // Reference model, indexed by floor number 1..5
  bit         m_acc  [1:5];
  bit         m_accd [1:5];
  int         m_cnt  [1:5];
  logic [5:1] m_pend;
  int         m_piso;
  int         m_tgt;
  int         m_fase;
  bit         m_up;

  gestor_llamadas #(.DEBOUNCE_CYCLES(DEB), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .boton     (boton),
    .fc1       (fcv[4]),
    .fc2       (fcv[3]),
    .fc3       (fcv[2]),
    .fc4       (fcv[1]),
    .fc5       (fcv[0]),
    .emergencia(emergencia),
    .selector  (selector),
    .pendientes(pendientes),
    .dir_subida(dir_subida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] piso_vec(input int f);
    logic [4:0] v;
    v = '0;
    if (f >= 1 && f <= 5) v[5-f] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] a_vec(input logic [5:1] p);
    logic [4:0] v;
    for (int f = 1; f <= 5; f++) v[5-f] = p[f];
    return v;
  endfunction

  function automatic int buscar(input logic [5:1] p, input int desde, input int paso);
    int r;
    r = 0;
    for (int f = desde + paso; f >= 1 && f <= 5; f += paso) begin
      if (r == 0 && p[f]) r = f;
    end
    return r;
  endfunction

  task automatic modelo_reset();
    for (int f = 1; f <= 5; f++) begin
      m_acc[f] = 0; m_accd[f] = 0; m_cnt[f] = 0;
    end
    m_pend = '0; m_piso = 1; m_tgt = 0; m_fase = 0; m_up = 1;
  endtask

  task automatic elegir(input logic [5:1] p, output int t);
    t = buscar(p, m_piso, m_up ? 1 : -1);
    if (t == 0) begin
      t = buscar(p, m_piso, m_up ? -1 : 1);
      if (t != 0) m_up = !m_up;
      else        t = m_piso;
    end
  endtask

  task automatic paso_modelo();
    logic [5:1] fc;
    logic [5:1] ant;
    bit         pulso [1:5];
    int         nfc, ufc, t;
    nfc = 0; ufc = 0;
    for (int f = 1; f <= 5; f++) begin
      fc[f] = fcv[5-f];
      if (fc[f]) begin nfc++; ufc = f; end
    end
    for (int f = 1; f <= 5; f++) begin
      pulso[f]  = m_acc[f] && !m_accd[f];
      m_accd[f] = m_acc[f];
      if (boton[5-f] != m_acc[f]) begin
        m_cnt[f]++;
        if (m_cnt[f] == DEB) begin m_acc[f] = boton[5-f]; m_cnt[f] = 0; end
      end else begin
        m_cnt[f] = 0;
      end
    end
    ant = m_pend;
    if (emergencia) begin
      m_pend = '0; m_fase = 0; m_tgt = 0; m_up = 0;
    end else begin
      for (int f = 1; f <= 5; f++) if (pulso[f] && !fc[f]) m_pend[f] = 1'b1;
      if (m_fase == 0) begin
        if (ant != '0) begin elegir(ant, t); m_tgt = t; m_fase = 1; end
      end else if (m_fase == 1) begin
        if (fc[m_tgt]) begin m_pend[m_tgt] = 1'b0; m_fase = 2; end
      end else begin
        m_fase = 0;
      end
    end
    if (nfc == 1) m_piso = ufc;
  endtask

  task automatic ciclo();
    @(negedge clk);
    if (!reset) modelo_reset();
    else        paso_modelo();
    chk("sel",  selector,   (m_fase == 1) ? piso_vec(m_tgt) : 5'd0);
    chk("pend", pendientes, a_vec(m_pend));
    chk("dir",  dir_subida, m_up);
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic pulsar(input logic [4:0] b, input int n);
    boton = b;
    ciclos(n);
    boton = '0;
  endtask

  task automatic esperar_sel();
    int w;
    w = 0;
    while (selector == 5'd0 && w < 4) begin ciclo(); w++; end
  endtask

  initial begin
    int r, idx;
    n_chk = 0; n_err = 0;
    reset = 1'b0; boton = '0; fcv = 5'b10000; emergencia = 1'b0;
    modelo_reset();
    ciclo();
    chk("rst_sel", selector, 5'b00000);
    chk("rst_pend", pendientes, 5'b00000);
    chk("rst_dir", dir_subida, 1'b1);
    ciclo();
    reset = 1'b1;

    // Short glitch on floor2 must not latch
    pulsar(5'b01000, 10);
    ciclos(20);
    chk("glitch_pend", pendientes, 5'b00000);

    // Floor4 call from floor1: latch after DEB+1 clks, selector one clk later
    boton = 5'b00010;
    for (int k = 1; k <= 20; k++) begin
      ciclo();
      if (k == DEB)     chk("t1_pend_early", pendientes, 5'b00000);
      if (k == DEB + 1) chk("t1_pend", pendientes, 5'b00010);
      if (k == DEB + 1) chk("t1_sel_early", selector, 5'b00000);
      if (k == DEB + 2) begin
        chk("t1_sel", selector, 5'b00010);
        chk("t1_dir", dir_subida, 1'b1);
      end
    end
    boton = '0;

    // New calls while travelling do not move the target
    fcv = '0;
    ciclos(3);
    pulsar(5'b01000, 20);
    pulsar(5'b00001, 20);
    chk("t3_pend", pendientes, 5'b01011);
    chk("t3_sel_held", selector, 5'b00010);
    fcv = 5'b00010;
    ciclo();
    chk("t3_arr_pend", pendientes, 5'b01001);
    chk("t3_arr_sel", selector, 5'b00000);
    esperar_sel();
    chk("t3_next_sel", selector, 5'b00001);
    chk("t3_next_dir", dir_subida, 1'b1);

    // At floor5 with floors 1 and 2 pending: reverse and take floor2 first
    fcv = '0;
    ciclos(3);
    pulsar(5'b10000, 20);
    fcv = 5'b00001;
    ciclo();
    chk("t4_pend", pendientes, 5'b11000);
    esperar_sel();
    chk("t4_sel", selector, 5'b01000);
    chk("t4_dir", dir_subida, 1'b0);
    fcv = '0; ciclos(3); fcv = 5'b01000; ciclo();
    esperar_sel();
    chk("t4_sel_f1", selector, 5'b10000);
    fcv = '0; ciclos(3); fcv = 5'b10000; ciclos(4);
    chk("t4_done_pend", pendientes, 5'b00000);

    // Emergency clears pending work and blocks new calls
    pulsar(5'b01011, 20);
    chk("t5_pend", pendientes, 5'b01011);
    chk("t5_sel", selector, 5'b01000);
    emergencia = 1'b1;
    ciclo();
    emergencia = 1'b0;
    chk("t5_em_pend", pendientes, 5'b00000);
    chk("t5_em_sel", selector, 5'b00000);
    chk("t5_em_dir", dir_subida, 1'b0);
    emergencia = 1'b1;
    boton = 5'b00100;
    ciclos(25);
    emergencia = 1'b0;
    ciclos(5);
    chk("t5_ign_pend", pendientes, 5'b00000);
    boton = '0;
    ciclos(20);

    // Two limit switches at once leave the position at floor2
    fcv = 5'b01000; ciclos(2);
    fcv = 5'b00110; ciclos(3);
    fcv = '0; ciclos(2);
    pulsar(5'b00100, 20);
    chk("t6_sel", selector, 5'b00100);
    chk("t6_dir", dir_subida, 1'b1);

    // Asynchronous reset while in DESTINO
    #2 reset = 1'b0;
    #1;
    modelo_reset();
    chk("t6_rst_sel", selector, 5'b00000);
    chk("t6_rst_pend", pendientes, 5'b00000);
    chk("t6_rst_dir", dir_subida, 1'b1);
    fcv = 5'b10000;
    ciclos(2);
    reset = 1'b1;

    // Random soak: hoist emulated from the model's own target
    for (int n = 0; n < 3000; n++) begin
      ciclo();
      r = $urandom_range(0, 99);
      if (r < 3)                     fcv = 5'($urandom);
      else if (r < 10 && m_fase == 1) fcv = piso_vec(m_tgt);
      else if (r < 14)               fcv = '0;
      if ($urandom_range(0, 24) == 0) begin
        idx = $urandom_range(0, 4);
        boton[idx] = ~boton[idx];
      end
      emergencia = ($urandom_range(0, 399) == 0);
    end
    ciclo();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
